// File: rtl/crc16_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// crc16_frame_ctrl_pkg
// Shared definitions for the CRC-16 frame sequencer: FSM state encoding,
// CRC-16/CCITT constants (poly 0x1021, preset 0xFFFF) and the good residue
// observed after a frame that carries its own ones'-complement CRC.
// ---------------------------------------------------------------------------
package crc16_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_BITS    = 3'd3,
        ST_CRC_OUT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;

    // Last index of the per-byte bit counter and of the CRC shift-out counter
    localparam logic [2:0]  BIT_LAST      = 3'd7;
    localparam logic [3:0]  CRC_BIT_LAST  = 4'd15;

endpackage

// File: rtl/crc16_frame_ctrl.sv
// ---------------------------------------------------------------------------
// crc16_frame_ctrl
// Frame-level sequencer for an external bit-serial CRC-16 engine. Payload
// bytes arrive over valid/ready and are fed MSB-first into the engine.
//   generate mode (i_mode=0): payload bits plus ~CRC are emitted on o_tx_*
//   check mode    (i_mode=1): payload + 2 CRC bytes; residue compared to RESIDUE
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_start/i_mode/i_len     frame start pulse, mode and byte count (IDLE only)
//   i_byte/i_byte_valid      payload byte stream; o_byte_ready accepts it
//   o_crc_reload/valid/data/shift  engine controls; i_crc_reg engine register
//   o_tx_bit/o_tx_valid      serial frame bitstream, MSB-first
//   o_busy                   high outside IDLE
//   o_done/o_crc_ok/o_crc_value  registered frame result, held until next DONE
// ---------------------------------------------------------------------------
module crc16_frame_ctrl
    import crc16_frame_ctrl_pkg::*;
#(
    parameter int          LEN_W   = 8,
    parameter logic [15:0] RESIDUE = CRC16_RESIDUE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [LEN_W-1:0] i_len,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    output logic             o_crc_reload,
    output logic             o_crc_valid,
    output logic             o_crc_data,
    output logic             o_crc_shift,
    input  logic [15:0]      i_crc_reg,
    output logic             o_tx_bit,
    output logic             o_tx_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_crc_ok,
    output logic [15:0]      o_crc_value
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_next_state;
    logic               r_mode;
    logic [LEN_W-1:0]   r_byte_cnt;
    logic [7:0]         r_sr;
    logic [2:0]         r_bit_cnt;
    logic [3:0]         r_crc_cnt;
    logic               r_done;
    logic               r_crc_ok;
    logic [15:0]        r_crc_value;
    logic               w_accept;
    logic               w_start;

    assign w_accept = (r_state == ST_FETCH) && i_byte_valid;
    assign w_start  = (r_state == ST_IDLE) && i_start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; after the payload, generate goes to CRC_OUT, check skips it
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (r_byte_cnt != LEN_ZERO) begin
                    w_next_state = ST_FETCH;
                end else if (r_mode) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_CRC_OUT;
                end
            end
            ST_FETCH: begin
                if (i_byte_valid) begin
                    w_next_state = ST_BITS;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_BITS: begin
                if (r_bit_cnt != BIT_LAST) begin
                    w_next_state = ST_BITS;
                end else if (r_byte_cnt != LEN_ZERO) begin
                    w_next_state = ST_FETCH;
                end else if (r_mode) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_CRC_OUT;
                end
            end
            ST_CRC_OUT: begin
                if (r_crc_cnt == CRC_BIT_LAST) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_CRC_OUT;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Moore output decode; CRC_OUT streams the complemented engine MSB while the engine shifts
    always_comb begin
        o_byte_ready = 1'b0;
        o_crc_reload = 1'b0;
        o_crc_valid  = 1'b0;
        o_crc_data   = 1'b0;
        o_crc_shift  = 1'b0;
        o_tx_bit     = 1'b0;
        o_tx_valid   = 1'b0;
        o_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
            end
            ST_LOAD: begin
                o_crc_reload = 1'b1;
            end
            ST_FETCH: begin
                o_byte_ready = 1'b1;
            end
            ST_BITS: begin
                o_crc_valid = 1'b1;
                o_crc_data  = r_sr[7];
                if (!r_mode) begin
                    o_tx_valid = 1'b1;
                    o_tx_bit   = r_sr[7];
                end else begin
                    o_tx_valid = 1'b0;
                    o_tx_bit   = 1'b0;
                end
            end
            ST_CRC_OUT: begin
                o_crc_valid = 1'b1;
                o_crc_shift = 1'b1;
                o_tx_valid  = 1'b1;
                o_tx_bit    = ~i_crc_reg[15];
            end
            ST_DONE: begin
                o_busy = 1'b1;
            end
            default: begin
                o_busy = 1'b1;
            end
        endcase
    end

    // Frame datapath: latched mode/length, byte shift register and the three counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_byte_cnt <= LEN_ZERO;
            r_sr       <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_crc_cnt  <= 4'd0;
        end else begin
            if (w_start) begin
                r_mode     <= i_mode;
                r_byte_cnt <= i_len;
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt - LEN_ONE;
            end else begin
                r_byte_cnt <= r_byte_cnt;
            end

            if (w_accept) begin
                r_sr      <= i_byte;
                r_bit_cnt <= 3'd0;
            end else if (r_state == ST_BITS) begin
                r_sr      <= {r_sr[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end else begin
                r_sr      <= r_sr;
                r_bit_cnt <= r_bit_cnt;
            end

            if (r_state == ST_LOAD) begin
                r_crc_cnt <= 4'd0;
            end else if (r_state == ST_CRC_OUT) begin
                r_crc_cnt <= r_crc_cnt + 4'd1;
            end else begin
                r_crc_cnt <= r_crc_cnt;
            end
        end
    end

    // Result registers; the first CRC_OUT cycle is the one where the engine still holds the final CRC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done      <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_crc_value <= 16'h0000;
        end else begin
            r_done <= (r_state == ST_DONE);

            if (w_start) begin
                r_crc_ok <= 1'b0;
            end else if (r_state == ST_DONE) begin
                r_crc_ok <= r_mode ? (i_crc_reg == RESIDUE) : 1'b1;
            end else begin
                r_crc_ok <= r_crc_ok;
            end

            if ((r_state == ST_CRC_OUT) && (r_crc_cnt == 4'd0)) begin
                r_crc_value <= ~i_crc_reg;
            end else if ((r_state == ST_DONE) && r_mode) begin
                r_crc_value <= i_crc_reg;
            end else begin
                r_crc_value <= r_crc_value;
            end
        end
    end

    assign o_done      = r_done;
    assign o_crc_ok    = r_crc_ok;
    assign o_crc_value = r_crc_value;

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_crc16_frame_ctrl
// Bench for crc16_frame_ctrl together with a bit-serial CRC-16 engine built
// beside it. Expected CRCs, residues, bitstreams and latencies come from a
// byte-level reference computation over the frame contents.
// ---------------------------------------------------------------------------
module tb_crc16_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_mode = 1'b0;
    logic [7:0]  i_len = 8'd0;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready, o_crc_reload, o_crc_valid, o_crc_data, o_crc_shift;
    logic        o_tx_bit, o_tx_valid, o_busy, o_done, o_crc_ok;
    logic [15:0] o_crc_value;
    logic [15:0] eng_reg;

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  frame_q [$];
    logic        tx_q [$];
    int          done_cyc;
    logic        timed_out;
    logic [15:0] got_val;
    logic        got_ok;
    logic        done_after;
    int          stall_crc_valid;

    crc16_frame_ctrl #(.LEN_W(8), .RESIDUE(16'h1D0F)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_len(i_len),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
        .o_crc_reload(o_crc_reload), .o_crc_valid(o_crc_valid), .o_crc_data(o_crc_data),
        .o_crc_shift(o_crc_shift), .i_crc_reg(eng_reg), .o_tx_bit(o_tx_bit),
        .o_tx_valid(o_tx_valid), .o_busy(o_busy), .o_done(o_done), .o_crc_ok(o_crc_ok),
        .o_crc_value(o_crc_value)
    );

    always #5 clk = ~clk;

    // Bit-serial CRC-16 engine that sits beside the sequencer
    always @(posedge clk or posedge rst) begin
        if (rst) eng_reg <= 16'h0000;
        else if (o_crc_reload) eng_reg <= 16'hFFFF;
        else if (o_crc_valid) begin
            if (o_crc_shift) eng_reg <= {eng_reg[14:0], 1'b0};
            else eng_reg <= {eng_reg[14:0], 1'b0} ^ ((eng_reg[15] ^ o_crc_data) ? 16'h1021 : 16'h0000);
        end
    end

    // Capture the transmitted bitstream away from the active edge
    always @(negedge clk) begin
        if (o_tx_valid) tx_q.push_back(o_tx_bit);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Byte-wise CRC-16/CCITT, preset FFFF, no final xor
    function automatic logic [15:0] ref_crc(input logic [7:0] b [$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) begin
            c = c ^ {b[i], 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Drive one frame from frame_q; optional stall before byte stall_idx and stray i_start at glitch_cyc
    task automatic run_frame(input logic mode, input int stall_idx, input int stall_len, input int glitch_cyc);
        int idx, stall_cnt, cyc;
        logic acc, seen;
        idx = 0; stall_cnt = 0; cyc = 0; acc = 1'b0; seen = 1'b0;
        stall_crc_valid = 0; timed_out = 1'b0; done_cyc = -1;
        tx_q.delete();
        @(negedge clk);
        i_start = 1'b1; i_mode = mode; i_len = 8'(frame_q.size());
        while (!seen && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (cyc == glitch_cyc) begin
                i_start = 1'b1; i_mode = ~mode; i_len = 8'd3;
            end else begin
                i_start = 1'b0; i_mode = mode; i_len = 8'(frame_q.size());
            end
            if (acc) idx++;
            if (o_done) begin
                seen = 1'b1; done_cyc = cyc; got_val = o_crc_value; got_ok = o_crc_ok;
                i_byte_valid = 1'b0;
            end else begin
                if (idx < frame_q.size()) begin
                    if (idx == stall_idx && stall_cnt < stall_len) begin
                        i_byte_valid = 1'b0;
                        if (o_byte_ready) begin
                            stall_cnt++;
                            if (o_crc_valid) stall_crc_valid++;
                        end
                    end else begin
                        i_byte_valid = 1'b1; i_byte = frame_q[idx];
                    end
                end else begin
                    i_byte_valid = 1'b0;
                end
                acc = i_byte_valid & o_byte_ready;
            end
        end
        i_start = 1'b0; i_byte_valid = 1'b0;
        if (!seen) timed_out = 1'b1;
        @(negedge clk);
        done_after = o_done;
    endtask

    // Run a frame and compare every observable result with the reference
    task automatic check_frame(input string tag, input logic mode, input int stall_idx, input int stall_len,
                               input int glitch_cyc);
        logic [7:0]  pay [$];
        logic        exp_bits [$];
        logic [15:0] crc, exp_val;
        logic        exp_ok;
        int          mism, exp_cyc, n;
        logic [15:0] tail;
        pay = frame_q;
        n = frame_q.size();
        crc = ref_crc(pay);
        if (mode) begin
            exp_val = crc; exp_ok = (crc == 16'h1D0F);
        end else begin
            exp_val = ~crc; exp_ok = 1'b1;
            foreach (pay[i]) for (int k = 7; k >= 0; k--) exp_bits.push_back(pay[i][k]);
            for (int k = 15; k >= 0; k--) exp_bits.push_back(exp_val[k]);
        end
        exp_cyc = (mode ? 3 : 19) + 9 * n + ((stall_idx < n) ? stall_len : 0);
        run_frame(mode, stall_idx, stall_len, glitch_cyc);
        chk({tag, "_timeout"}, timed_out, 1'b0);
        chk({tag, "_value"}, got_val, exp_val);
        chk({tag, "_ok"}, got_ok, exp_ok);
        chk({tag, "_latency"}, done_cyc, exp_cyc);
        chk({tag, "_done_pulse"}, done_after, 1'b0);
        chk({tag, "_stall_adv"}, stall_crc_valid, 0);
        chk({tag, "_tx_count"}, tx_q.size(), exp_bits.size());
        mism = 0;
        for (int i = 0; i < tx_q.size() && i < exp_bits.size(); i++) if (tx_q[i] !== exp_bits[i]) mism++;
        chk({tag, "_tx_bits"}, mism, 0);
        if (!mode && tx_q.size() >= 16) begin
            for (int k = 0; k < 16; k++) tail[15-k] = tx_q[tx_q.size() - 16 + k];
            chk({tag, "_tx_tail"}, tail, exp_val);
        end
    endtask

    task automatic load_123456789();
        frame_q.delete();
        for (int i = 0; i < 9; i++) frame_q.push_back(8'h31 + 8'(i));
    endtask

    initial begin
        int nacc, guard, n, k;
        logic acc, mode;
        logic [15:0] c;
        logic [7:0] pay [$];

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {o_byte_ready, o_crc_reload, o_crc_valid, o_crc_data, o_crc_shift, o_tx_bit,
                              o_tx_valid, o_busy, o_done, o_crc_ok, o_crc_value}, 27'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", o_busy, 1'b0);

        // 1: generate "123456789"
        load_123456789();
        check_frame("gen_std", 1'b0, 99, 0, 0);
        chk("gen_std_D64E", got_val, 16'hD64E);
        chk("gen_std_bits88", tx_q.size(), 88);

        // 2: check "123456789",D6,4E and a corrupted copy
        load_123456789(); frame_q.push_back(8'hD6); frame_q.push_back(8'h4E);
        check_frame("chk_good", 1'b1, 99, 0, 0);
        chk("chk_good_const", {got_ok, got_val}, {1'b1, 16'h1D0F});
        frame_q[2] = frame_q[2] ^ 8'h01;
        check_frame("chk_bad", 1'b1, 99, 0, 0);
        chk("chk_bad_const", got_ok, 1'b0);

        // 3: generate, empty frame
        frame_q.delete();
        check_frame("gen_len0", 1'b0, 99, 0, 0);
        chk("gen_len0_const", {got_val, 8'(done_cyc)}, {16'h0000, 8'd19});

        // Check, empty frame: preset residue is not the good residue
        check_frame("chk_len0", 1'b1, 99, 0, 0);
        chk("chk_len0_const", {got_ok, got_val}, {1'b0, 16'hFFFF});

        // 4: stall 5 cycles before byte 5
        load_123456789();
        check_frame("gen_stall", 1'b0, 4, 5, 0);
        chk("gen_stall_D64E", got_val, 16'hD64E);

        // 5: reset during BITS of byte 2
        @(negedge clk);
        i_start = 1'b1; i_mode = 1'b0; i_len = 8'd9;
        @(negedge clk);
        i_start = 1'b0; i_byte_valid = 1'b1; i_byte = 8'h31;
        nacc = 0; guard = 0;
        while (nacc < 2 && guard < 200) begin
            acc = o_byte_ready;
            @(negedge clk);
            if (acc) nacc++;
            guard++;
        end
        chk("rst_reached_byte2", nacc, 2);
        i_byte_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_bits", {o_busy, o_crc_valid, o_tx_valid}, 3'b111);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {o_byte_ready, o_crc_reload, o_crc_valid, o_crc_data, o_crc_shift, o_tx_bit,
                                o_tx_valid, o_busy, o_done, o_crc_ok, o_crc_value}, 27'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst_idle", o_busy, 1'b0);
        load_123456789();
        check_frame("gen_glitch", 1'b0, 99, 0, 5);
        chk("gen_glitch_D64E", got_val, 16'hD64E);

        // Randomized frames in both modes
        for (int f = 0; f < 24; f++) begin
            mode = 1'($urandom_range(1, 0));
            n = $urandom_range(12, 0);
            pay.delete();
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
            if (mode && $urandom_range(3, 0) != 0) begin
                c = ~ref_crc(pay);
                pay.push_back(c[15:8]); pay.push_back(c[7:0]);
                if ($urandom_range(1, 0) == 1) begin
                    k = $urandom_range(pay.size() - 1, 0);
                    pay[k] = pay[k] ^ (8'h01 << $urandom_range(7, 0));
                end
            end
            frame_q = pay;
            check_frame($sformatf("rnd%0d", f), mode, $urandom_range(14, 0), $urandom_range(4, 0), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
